// File: rtl/seq_pkg.sv
// seq_pkg
// Shared definitions for the serial pattern blocks (generator and the
// sequence detectors that consume its output).
//   state_e    : three-state transfer FSM encoding (IDLE / SHIFT / DONE)
//   DEFAULT_PW : default maximum pattern width in bits
//   DEFAULT_RW : default repeat-count width in bits
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int DEFAULT_PW = 8;
  localparam int DEFAULT_RW = 4;

endpackage

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen
// Serialises a captured pattern MSB-first (bit len down to bit 0), repeating
// it reps extra times back-to-back, then pulses done for one cycle.
// Ports:
//   clk     : clock, all state changes on the rising edge
//   reset   : asynchronous, active-low reset
//   start   : transfer request, only looked at while idle
//   pattern : bits to send (PW wide)
//   len     : pattern length minus one ($clog2(PW) wide)
//   reps    : number of extra repetitions (RW wide)
//   x       : registered serial data, 0 whenever x_valid is low
//   x_valid : registered, x carries a pattern bit this cycle
//   busy    : high while the FSM is not idle
//   done    : registered one-cycle pulse after the final bit
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int PW = DEFAULT_PW,
  parameter int RW = DEFAULT_RW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PW-1:0]         pattern,
  input  logic [$clog2(PW)-1:0] len,
  input  logic [RW-1:0]         reps,
  output logic                  x,
  output logic                  x_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int LW = $clog2(PW);

  state_e          state_q, state_d;
  logic [PW-1:0]   pattern_q, pattern_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   rep_q, rep_d;
  logic            x_q, x_d;
  logic            x_valid_q, x_valid_d;
  logic            done_q, done_d;

  logic [LW-1:0]   len_sat;
  logic            last_bit;

  // A len beyond the physical pattern width would index past the register,
  // so it is clamped to the top bit before it is captured.
  always_comb begin
    len_sat = len;
    if (int'(len) > PW - 1) begin
      len_sat = LW'(PW - 1);
    end
  end

  // Final bit of the final repetition is on the line.
  assign last_bit = (idx_q == '0) && (rep_q == '0);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, then walk the bit index down and reload it
  // for each repetition so repeats follow with no gap cycle.
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pattern_d = pattern;
          len_d     = len_sat;
          idx_d     = len_sat;
          rep_d     = reps;
        end
      end
      SHIFT: begin
        if (idx_q != '0) begin
          idx_d = idx_q - LW'(1);
        end else if (rep_q != '0) begin
          rep_d = rep_q - RW'(1);
          idx_d = len_q;
        end
      end
      default: ;
    endcase
  end

  // Output logic. The first bit comes straight from the input bus so it is
  // on the line one cycle after the accept edge; later bits use the next
  // index from the datapath so the reload case picks captured[len].
  always_comb begin
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d       = pattern[len_sat];
          x_valid_d = 1'b1;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          done_d = 1'b1;
        end else begin
          x_d       = pattern_q[idx_d];
          x_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset aborts any transfer at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen
// Scoreboard bench for seq_pattern_gen: each issued transfer pushes its
// expected bit stream plus a done marker; a monitor pops on every x_valid or
// done cycle and compares.
module tb_seq_pattern_gen;

  localparam int PW = 8;
  localparam int RW = 4;
  localparam int LW = $clog2(PW);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] pattern = '0;
  logic [LW-1:0] len = '0;
  logic [RW-1:0] reps = '0;
  logic          x, x_valid, busy, done;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit is_done;
    bit val;
  } exp_t;

  exp_t exp_q[$];

  seq_pattern_gen #(.PW(PW), .RW(RW)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .x       (x),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got event with empty scoreboard, expected none (t=%0t)", name, $time);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin : monitor
    exp_t e;
    bit   prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_valid = 1'b0;
      end else begin
        if (!x_valid) check_output("x_zero_when_invalid", int'(x), 0);
        check_output("busy_decode", int'(busy), int'(x_valid || done));
        if (prev_valid && !x_valid) check_output("done_after_last_bit", int'(done), 1);
        if (x_valid) begin
          if (exp_q.size() == 0) begin
            flag_fail("unexpected_bit");
          end else begin
            e = exp_q.pop_front();
            check_output("bit_not_done_slot", int'(x_valid), int'(!e.is_done));
            if (!e.is_done) check_output("x_bit", int'(x), int'(e.val));
          end
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            flag_fail("unexpected_done");
          end else begin
            e = exp_q.pop_front();
            check_output("done_slot", int'(done), int'(e.is_done));
          end
        end
        prev_valid = x_valid;
      end
    end
  end

  // Issues one transfer at the current falling edge (FSM must be idle) and
  // follows it to its done cycle. n = (len+1)*(reps+1) valid cycles, then done.
  task automatic apply_stimulus(input logic [PW-1:0] p, input int l, input int r,
                                input bit hold, input bit scramble);
    int sat;
    int n;
    sat = (l > PW - 1) ? PW - 1 : l;
    n   = (sat + 1) * (r + 1);
    pattern = p;
    len     = LW'(l);
    reps    = RW'(r);
    start   = 1'b1;
    for (int k = 0; k <= r; k++) begin
      for (int i = sat; i >= 0; i--) begin
        exp_q.push_back('{1'b0, p[i]});
      end
    end
    exp_q.push_back('{1'b1, 1'b0});
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (scramble) begin
        pattern = PW'($urandom);
        len     = LW'($urandom);
        reps    = RW'($urandom);
      end
      if (c == 1) check_output("first_bit_latency", int'(x_valid), 1);
      check_output("x_valid_contiguous", int'(x_valid), int'(c <= n));
      check_output("done_timing", int'(done), int'(c == n + 1));
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin : stimulus
    // Reset state.
    repeat (2) @(negedge clk);
    check_output("reset_x", int'(x), 0);
    check_output("reset_x_valid", int'(x_valid), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 0101 once.
    apply_stimulus(8'b0000_0101, 3, 0, 1'b0, 1'b0);
    @(negedge clk);
    // 0101 three times.
    apply_stimulus(8'b0000_0101, 3, 2, 1'b0, 1'b0);
    @(negedge clk);
    // Single bit.
    apply_stimulus(8'b0000_0001, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    // Widest, longest transfer: 128 bits.
    apply_stimulus(8'hA5, 7, 15, 1'b0, 1'b0);
    @(negedge clk);

    // start held high with inputs scrambled mid-transfer.
    for (int t = 0; t < 3; t++) begin
      apply_stimulus(PW'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'b1, 1'b1);
      start = 1'b1;
      @(negedge clk);
      check_output("idle_gap", int'(x_valid), 0);
    end
    apply_stimulus(8'h96, 5, 1, 1'b1, 1'b1);
    start = 1'b0;
    @(negedge clk);

    // Reset in the middle of bit 3 (bit 3 of 0x3C from the top is 1).
    pattern = 8'h3C;
    len     = 3'd7;
    reps    = 4'd0;
    start   = 1'b1;
    for (int i = 7; i >= 0; i--) exp_q.push_back('{1'b0, pattern[i]});
    exp_q.push_back('{1'b1, 1'b0});
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_output("bit3_before_reset", int'(x), 1);
    #2 reset = 1'b0;
    #1;
    check_output("async_reset_x", int'(x), 0);
    check_output("async_reset_x_valid", int'(x_valid), 0);
    check_output("async_reset_busy", int'(busy), 0);
    check_output("async_reset_done", int'(done), 0);
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("no_done_in_reset", int'(done), 0);
    end
    reset = 1'b1;
    apply_stimulus(8'hC3, 7, 1, 1'b0, 1'b1);
    @(negedge clk);

    // Randomised transfers with random idle spacing.
    for (int t = 0; t < 20; t++) begin
      apply_stimulus(PW'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b0, 1'b1);
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter PW, default 8: maximum pattern width in bits.
REQ-002 SHALL have parameter RW, default 4: repeat-count width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to transmit; sampled only in IDLE.
REQ-006 SHALL have port pattern, input, PW bits: bits to send, MSB-first from bit index len down to 0.
REQ-007 SHALL have port len, input, $clog2(PW) bits: pattern length minus 1 (0 means 1 bit).
REQ-008 SHALL have port reps, input, RW bits: extra repetitions (0 means send once).
REQ-009 SHALL have port x, output, 1 bit: serial data, registered.
REQ-010 SHALL have port x_valid, output, 1 bit: x carries a pattern bit this cycle, registered.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse after the last bit, registered.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 IDLE with start=1 at an edge SHALL capture pattern, len and reps, load bit index = len, set x <= pattern[len] and x_valid <= 1, and go to SHIFT.
REQ-015 start=1 in SHIFT or DONE SHALL be ignored; inputs SHALL NOT be re-sampled mid-transfer.
REQ-016 Inputs pattern, len and reps SHALL be don't-care outside the accept edge.
REQ-017 In SHIFT, each edge SHALL advance: if index>0, index decrements and x takes the captured bit at the new index.
REQ-018 In SHIFT with index=0 and remaining reps>0, the edge SHALL decrement reps, reload index = len, and set x = captured[len]; there SHALL be no gap cycle between repetitions.
REQ-019 In SHIFT with index=0 and reps=0, the edge SHALL clear x_valid and x (x=0) and go to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle, then go to IDLE unconditionally.
REQ-021 First bit latency SHALL be 1 cycle from the start sample; a transfer SHALL be exactly (len+1)*(reps+1) consecutive x_valid cycles.
REQ-022 done SHALL be high in the cycle after the last x_valid cycle.
REQ-023 busy SHALL be a decode of state, asserted from the first x_valid cycle through the done cycle inclusive.
REQ-024 A new start SHALL be accepted earliest in the cycle after done; back-to-back transfers SHALL therefore have a 2-cycle minimum gap in x_valid.
REQ-025 x SHALL be 0 whenever x_valid=0.
REQ-026 len values >= PW SHALL be saturated to PW-1 at capture.
REQ-027 The counter widths SHALL be exactly $clog2(PW) for the index and RW for the repeat count, with no wrap-around beyond the decrement to 0.

Reset
REQ-028 reset=0 SHALL asynchronously force state=IDLE, x=0, x_valid=0, done=0, index=0, reps counter=0, and the pattern register to 0.
REQ-029 Assertion of reset mid-transfer SHALL abort the transfer immediately with no done pulse.
REQ-030 After release, the first accept SHALL be possible at the first rising edge with reset=1.

Structure
REQ-031 The FSM state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and default widths SHALL reside in shared package seq_pkg, which the sequence-detector blocks SHALL also use.
REQ-032 The block SHALL be a single module with no sub-module; the next-state, datapath and output logic SHALL be separate processes.

Verification
REQ-033 pattern=8'b0000_0101, len=3, reps=0, start pulse at cycle 0 -> x=0,1,0,1 with x_valid high in cycles 1-4, done=1 in cycle 5, busy in cycles 1-5.
REQ-034 Same pattern with reps=2, output driving the 0101 Mealy detector -> 12 bits 010101010101 and detector z=1 on bits 4, 6, 8, 10 and 12 (5 hits).
REQ-035 len=0, pattern[0]=1, reps=0 -> single x=1 cycle, done the following cycle.
REQ-036 start held high continuously -> transfers separated by exactly 2 non-valid cycles; pattern changes during SHIFT have no effect on x.
REQ-037 reset pulled low in the middle of bit 3 -> x, x_valid, busy and done go to 0 asynchronously; no done pulse; a fresh start after release transmits correctly.
REQ-038 len=7, pattern=8'hA5, reps=15 -> 128 contiguous valid bits repeating 10100101, with done in cycle 129.
